// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
//   CH_N   : number of output channels
//   sel_t  : channel index type (also the round-robin pointer type)
//   mode_e : target selection mode (explicit select lines or round-robin)
package demux_pkg;

  localparam int unsigned CH_N = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

endpackage

// File: rtl/demux_1x4_stream_if.sv
// Bundle of the producer-side and consumer-side signals of demux_1x4_stream.
//   i, s0, s1, mode, in_valid, in_ready : producer side
//   y0..y3, y_valid, y_ready            : the four consumer channels
//   rr_ptr                              : current round-robin target
// Modport slave is the demultiplexer; modport master is its environment.
interface demux_1x4_stream_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) ();

  logic [WIDTH-1:0] i;
  logic             s0;
  logic             s1;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [CH_N-1:0]  y_valid;
  logic [CH_N-1:0]  y_ready;
  sel_t             rr_ptr;

  modport slave (
    input  i, s0, s1, mode, in_valid, y_ready,
    output in_ready, y0, y1, y2, y3, y_valid, rr_ptr
  );

  modport master (
    output i, s0, s1, mode, in_valid, y_ready,
    input  in_ready, y0, y1, y2, y3, y_valid, rr_ptr
  );

endinterface

// File: rtl/demux_out_slot.sv
// One-entry output holding register with a valid/ready drain handshake.
//   load        : write data_in this edge (caller guarantees slot_ready)
//   data_in     : word to store
//   drain_ready : downstream consumer ready
//   data, valid : held word and its valid flag
//   slot_ready  : slot can take a word this cycle (empty or draining now)
module demux_out_slot #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             drain_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             slot_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      // A refill wins over a simultaneous drain so the channel stays full.
      data_d  = data_in;
      valid_d = 1'b1;
    end else if (valid_q && drain_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign slot_ready = !valid_q || drain_ready;

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : producer word/handshake, select lines, mode, the four
//                channel outputs with per-channel valid/ready, and rr_ptr
// The target channel is {s1,s0} in select mode or the round-robin pointer
// in round-robin mode; the pointer advances only on an accepted word.
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_1x4_stream_if.slave     bus
);

  mode_e            mode;
  sel_t             sel;
  sel_t             rr_ptr_q, rr_ptr_d;
  logic             in_ready;
  logic             accept;
  logic [CH_N-1:0]  load;
  logic [CH_N-1:0]  slot_ready;
  logic [CH_N-1:0]  slot_valid;
  logic [WIDTH-1:0] slot_data [CH_N];

  always_comb begin
    mode     = mode_e'(bus.mode);
    sel      = (mode == MODE_RR) ? rr_ptr_q : {bus.s1, bus.s0};
    // Slots read as empty during reset, so gate with rst_n explicitly.
    in_ready = rst_n && slot_ready[sel];
    accept   = bus.in_valid && in_ready;
    rr_ptr_d = rr_ptr_q;
    if (accept && (mode == MODE_RR)) begin
      rr_ptr_d = rr_ptr_q + sel_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar g = 0; g < CH_N; g++) begin : g_slot
    assign load[g] = accept && (sel == sel_t'(g));

    demux_out_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load[g]),
      .data_in     (bus.i),
      .drain_ready (bus.y_ready[g]),
      .data        (slot_data[g]),
      .valid       (slot_valid[g]),
      .slot_ready  (slot_ready[g])
    );
  end

  assign bus.in_ready = in_ready;
  assign bus.y0       = slot_data[0];
  assign bus.y1       = slot_data[1];
  assign bus.y2       = slot_data[2];
  assign bus.y3       = slot_data[3];
  assign bus.y_valid  = slot_valid;
  assign bus.rr_ptr   = rr_ptr_q;

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed testbench for demux_1x4_stream (WIDTH = 1).
module tb_demux_1x4_stream;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux_1x4_stream_if #(.WIDTH(1)) bus ();

  demux_1x4_stream #(
    .WIDTH (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic       iv;
    logic       din;
    logic [3:0] yr;
    logic       ir;   // in_ready before the edge
    logic [3:0] vld;  // y_valid after the edge
    logic [3:0] yv;   // {y3,y2,y1,y0} after the edge
    logic [1:0] rr;   // rr_ptr after the edge
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic iv,
                       input logic d, input logic [3:0] yr);
    bus.mode     = m;
    bus.s1       = s[1];
    bus.s0       = s[0];
    bus.in_valid = iv;
    bus.i        = d;
    bus.y_ready  = yr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] yvec();
    return {bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_y"},        {28'd0, yvec()},      32'd0);
    chk({tag, "_valid"},    {28'd0, bus.y_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_rr"},       {30'd0, bus.rr_ptr},  32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //           mode  sel    iv    din   yr       ir    vld      yv       rr
    // explicit select, all consumers ready
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0001, 2'd0};
    vecs[1]  = '{1'b0, 2'b01, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0001, 2'd0};
    vecs[2]  = '{1'b0, 2'b10, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0101, 2'd0};
    vecs[3]  = '{1'b0, 2'b11, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000, 4'b1101, 2'd0};
    // backpressure on channel 2, then pass-through refill
    vecs[4]  = '{1'b0, 2'b10, 1'b1, 1'b1, 4'b0000, 1'b1, 4'b1100, 4'b1101, 2'd0};
    vecs[5]  = '{1'b0, 2'b10, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b1100, 4'b1101, 2'd0};
    vecs[6]  = '{1'b0, 2'b10, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b1100, 4'b1001, 2'd0};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0100, 4'b1001, 2'd0};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b1001, 2'd0};
    // round-robin, six words 1,0,1,1,0,1
    vecs[9]  = '{1'b1, 2'b00, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 4'b1001, 2'd1};
    vecs[10] = '{1'b1, 2'b00, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b1001, 2'd2};
    vecs[11] = '{1'b1, 2'b00, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 4'b1101, 2'd3};
    vecs[12] = '{1'b1, 2'b00, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000, 4'b1101, 2'd0};
    vecs[13] = '{1'b1, 2'b00, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0001, 4'b1100, 2'd1};
    vecs[14] = '{1'b1, 2'b00, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 4'b1110, 2'd2};
    // back to explicit select: pointer is kept
    vecs[15] = '{1'b0, 2'b00, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 4'b1111, 2'd2};

    rst_n = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 4'b0000);
    #12;
    chk_reset("por");
    rst_n = 1'b1;
    step();

    for (int unsigned n = 0; n < 16; n++) begin
      drive(vecs[n].mode, vecs[n].sel, vecs[n].iv, vecs[n].din, vecs[n].yr);
      #1;
      chk($sformatf("v%0d_in_ready", n), {31'd0, bus.in_ready}, {31'd0, vecs[n].ir});
      step();
      chk($sformatf("v%0d_valid", n), {28'd0, bus.y_valid}, {28'd0, vecs[n].vld});
      chk($sformatf("v%0d_y", n),     {28'd0, yvec()},      {28'd0, vecs[n].yv});
      chk($sformatf("v%0d_rr", n),    {30'd0, bus.rr_ptr},  {30'd0, vecs[n].rr});
    end

    // Fill every channel with consumers stalled, then reset mid-cycle.
    drive(1'b0, 2'b01, 1'b1, 1'b1, 4'b0000); step();
    drive(1'b0, 2'b10, 1'b1, 1'b1, 4'b0000); step();
    drive(1'b0, 2'b11, 1'b1, 1'b1, 4'b0000); step();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 4'b0000);
    #1;
    chk("full_valid", {28'd0, bus.y_valid}, 32'h0000_000f);
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    #3;
    rst_n = 1'b1;
    drive(1'b1, 2'b00, 1'b1, 1'b1, 4'b0000);
    step();
    chk("post_rst_valid", {28'd0, bus.y_valid}, 32'h0000_0001);
    chk("post_rst_y",     {28'd0, yvec()},      32'h0000_0001);
    chk("post_rst_rr",    {30'd0, bus.rr_ptr},  32'd1);

    // Round-robin stall: fill channel 1 explicitly, pointer sits at 1.
    drive(1'b0, 2'b01, 1'b1, 1'b1, 4'b0000);
    step();
    chk("stall_setup_valid", {28'd0, bus.y_valid}, 32'h0000_0003);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 4'b1101);
    for (int unsigned c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
      step();
      chk($sformatf("stall%0d_rr", c), {30'd0, bus.rr_ptr}, 32'd1);
      chk($sformatf("stall%0d_y", c),  {28'd0, yvec()},     32'h0000_0003);
      chk($sformatf("stall%0d_v1", c), {31'd0, bus.y_valid[1]}, 32'd1);
    end
    bus.y_ready = 4'b1111;
    #1;
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("release_rr",    {30'd0, bus.rr_ptr},  32'd2);
    chk("release_y",     {28'd0, yvec()},      32'h0000_0001);
    chk("release_valid", {28'd0, bus.y_valid}, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
